// File: rtl/mem_responder_if.sv
// Packet types and the request/response bundle between the fill queue
// arbiter (master) and the memory responder (slave).
//
// Handshake: a request is consumed on a rising clock edge when mem_req and
// mem_gnt are both high in that cycle; mem_gnt is a same-cycle combinational
// answer and mem_req_pkt must be stable and X-free whenever mem_req is high.
// mem_rsp_pkt is a registered broadcast with no back-pressure: the master
// must accept it in any cycle where mem_rsp_pkt.valid is high.
package mem_responder_pkg;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } t_mem_req_pkt;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } t_mem_rsp_pkt;
endpackage

interface mem_responder_if;
   import mem_responder_pkg::*;

   logic         mem_req;
   t_mem_req_pkt mem_req_pkt;
   logic         mem_gnt;
   t_mem_rsp_pkt mem_rsp_pkt;

   modport master (output mem_req, output mem_req_pkt, input mem_gnt, input mem_rsp_pkt);
   modport slave  (input mem_req, input mem_req_pkt, output mem_gnt, output mem_rsp_pkt);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: grants one request per cycle into a table of
// QDEPTH outstanding slots and answers each one with a tagged response
// LATENCY cycles after its grant. Response data is the address repeated in
// 32-bit chunks, chunk k = addr + k, so every response is checkable.
//
// Optional build macro MEM_RSP_RANDOM_LAT_EN: adds 0..7 cycles of LFSR
// jitter to each request's latency and picks the lowest-index ready slot,
// so responses may return out of order. Without it, latency is fixed and
// the oldest ready slot is always chosen (strictly in-order).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int LATENCY = 8,
   parameter int QDEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   mem_responder_if.slave               bus,
   output logic [$clog2(QDEPTH+1)-1:0]  num_outstanding
);

   localparam int IDX_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH+1);
   localparam int NCHUNK = DATA_W / 32;

   logic [QDEPTH-1:0] slot_valid;
   // Set for the one cycle after a slot frees; stops a same-cycle re-grant.
   logic [QDEPTH-1:0] slot_blocked;
   logic [QDEPTH-1:0] slot_ready;
   logic [ID_W-1:0]   slot_id    [QDEPTH];
   logic [ADDR_W-1:0] slot_addr  [QDEPTH];
   logic [5:0]        slot_timer [QDEPTH];

   logic              free_any;
   logic [IDX_W-1:0]  alloc_idx;
   logic              grant;
   logic              sel_any;
   logic [IDX_W-1:0]  sel_idx;
   logic [DATA_W-1:0] sel_data;
   logic [5:0]        timer_load;
   t_mem_rsp_pkt      rsp_q;

   // Only id and addr of the request matter; mem_req qualifies it.
   logic unused_req_valid;
   assign unused_req_valid = bus.mem_req_pkt.valid;

`ifdef MEM_RSP_RANDOM_LAT_EN
   logic [15:0] lfsr;
   logic [6:0]  load_wide;

   // Free-running jitter source, x^16+x^14+x^13+x^11+1.
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // Base load plus jitter, clamped to the 6-bit timer range.
   always_comb begin
      load_wide  = 7'(LATENCY - 2) + {4'd0, lfsr[2:0]};
      timer_load = (load_wide > 7'd63) ? 6'd63 : load_wide[5:0];
   end

   // Lowest-index ready slot wins.
   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      for (int i = QDEPTH - 1; i >= 0; i--) begin
         if (slot_ready[i]) begin
            sel_any = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [3:0] slot_seq [QDEPTH];
   logic [3:0] alloc_seq;
   logic [3:0] best_age;

   assign timer_load = 6'(LATENCY - 2);

   // Oldest ready slot wins; age is the modulo-16 distance behind the next tag.
   always_comb begin
      sel_any  = 1'b0;
      sel_idx  = '0;
      best_age = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (slot_ready[i] && (!sel_any || 4'(alloc_seq - slot_seq[i] - 4'd1) > best_age)) begin
            sel_any  = 1'b1;
            sel_idx  = IDX_W'(i);
            best_age = 4'(alloc_seq - slot_seq[i] - 4'd1);
         end
      end
   end

   // Allocation tags record grant order for the oldest-first select.
   always_ff @(posedge clk) begin
      if (reset) begin
         alloc_seq <= '0;
      end else if (grant) begin
         slot_seq[alloc_idx] <= alloc_seq;
         alloc_seq           <= alloc_seq + 4'd1;
      end
   end
`endif

   // Lowest-index free, unblocked slot receives the next grant.
   always_comb begin
      free_any  = 1'b0;
      alloc_idx = '0;
      for (int i = QDEPTH - 1; i >= 0; i--) begin
         slot_ready[i] = slot_valid[i] && (slot_timer[i] == 6'd0);
         if (!slot_valid[i] && !slot_blocked[i]) begin
            free_any  = 1'b1;
            alloc_idx = IDX_W'(i);
         end
      end
   end

   assign grant           = bus.mem_req && !reset && free_any;
   assign bus.mem_gnt     = grant;
   assign bus.mem_rsp_pkt = rsp_q;

   // Deterministic response payload from the selected slot's address.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         sel_data[k*32 +: 32] = slot_addr[sel_idx][31:0] + 32'(k);
      end
   end

   // Slot table, timers, response register and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid      <= '0;
         slot_blocked    <= '0;
         rsp_q           <= '0;
         num_outstanding <= '0;
      end else begin
         slot_blocked <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            if (slot_valid[i] && slot_timer[i] != 6'd0) begin
               slot_timer[i] <= slot_timer[i] - 6'd1;
            end
         end
         if (sel_any) begin
            slot_valid[sel_idx]   <= 1'b0;
            slot_blocked[sel_idx] <= 1'b1;
            rsp_q <= '{valid: 1'b1, id: slot_id[sel_idx], addr: slot_addr[sel_idx], data: sel_data};
         end else begin
            rsp_q.valid <= 1'b0;
         end
         if (grant) begin
            slot_valid[alloc_idx] <= 1'b1;
            slot_id[alloc_idx]    <= bus.mem_req_pkt.id;
            slot_addr[alloc_idx]  <= bus.mem_req_pkt.addr;
            slot_timer[alloc_idx] <= timer_load;
         end
         num_outstanding <= num_outstanding + CNT_W'(grant) - CNT_W'(sel_any);
      end
   end

`ifndef SYNTHESIS
   a_count_bound : assert property (@(posedge clk) disable iff (reset)
      num_outstanding <= CNT_W'(QDEPTH));
   a_sel_valid : assert property (@(posedge clk) disable iff (reset)
      sel_any |-> slot_valid[sel_idx]);
   a_req_known : assert property (@(posedge clk) disable iff (reset)
      bus.mem_req |-> !$isunknown(bus.mem_req_pkt));
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at LATENCY=8, QDEPTH=4 (default build).
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int L = 8;
   localparam int Q = 4;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] num_outstanding;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_responder_if bus_if ();

   mem_responder #(.LATENCY(L), .QDEPTH(Q)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus_if),
      .num_outstanding (num_outstanding)
   );

   task automatic drive(input logic req, input logic [3:0] id, input logic [31:0] addr);
      bus_if.mem_req     = req;
      bus_if.mem_req_pkt = '{valid: req, id: id, addr: addr};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 4'd0, 32'd0);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 4'd7, 32'h55);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (bus_if.mem_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt k=%0d got=%b exp=0", k, bus_if.mem_gnt);
         end
         next_cycle();
      end
      reset = 1'b0;
      drive(1'b0, 4'd0, 32'd0);
      #1;
      n_checks++;
      if (bus_if.mem_rsp_pkt !== '0) begin
         n_fail++; $display("FAIL reset_rsp got=%h exp=0", bus_if.mem_rsp_pkt);
      end
      n_checks++;
      if (num_outstanding !== 3'd0) begin
         n_fail++; $display("FAIL reset_cnt got=%0d exp=0", num_outstanding);
      end
      n_checks++;
      if (bus_if.mem_gnt !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle_gnt got=%b exp=0", bus_if.mem_gnt);
      end
      next_cycle();
      idle(3);
   endtask

   task automatic test_single();
      logic [31:0] a = 32'h1000;
      for (int k = 0; k < 12; k++) begin
         drive(k == 0, 4'd3, a);
         #1;
         n_checks++;
         if (bus_if.mem_gnt !== (k == 0)) begin
            n_fail++; $display("FAIL single_gnt k=%0d got=%b exp=%b", k, bus_if.mem_gnt, k == 0);
         end
         n_checks++;
         if (bus_if.mem_rsp_pkt.valid !== (k == 8)) begin
            n_fail++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, bus_if.mem_rsp_pkt.valid, k == 8);
         end
         if (k == 8) begin
            n_checks++;
            if ({bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr, bus_if.mem_rsp_pkt.data} !==
                {4'd3, 32'h1000, 32'h1001, 32'h1000}) begin
               n_fail++; $display("FAIL single_fields got=%h exp=3_00001000_0000100100001000",
                                  {bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr, bus_if.mem_rsp_pkt.data});
            end
         end
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [4];
      logic [31:0] ea;
      int peak = 0;
      for (int i = 0; i < 4; i++) a[i] = $urandom;
      for (int k = 0; k < 15; k++) begin
         drive(k < 4, 4'(k), a[k % 4]);
         #1;
         if (int'(num_outstanding) > peak) peak = int'(num_outstanding);
         n_checks++;
         if (bus_if.mem_gnt !== (k < 4)) begin
            n_fail++; $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, bus_if.mem_gnt, k < 4);
         end
         n_checks++;
         if (bus_if.mem_rsp_pkt.valid !== (k >= 8 && k <= 11)) begin
            n_fail++; $display("FAIL b2b_valid k=%0d got=%b", k, bus_if.mem_rsp_pkt.valid);
         end
         if (k >= 8 && k <= 11) begin
            ea = a[k - 8];
            n_checks++;
            if ({bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr, bus_if.mem_rsp_pkt.data} !==
                {4'(k - 8), ea, ea + 32'd1, ea}) begin
               n_fail++; $display("FAIL b2b_fields k=%0d got=%h exp=%h", k,
                                  {bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr, bus_if.mem_rsp_pkt.data},
                                  {4'(k - 8), ea, ea + 32'd1, ea});
            end
         end
         next_cycle();
      end
      n_checks++;
      if (peak != 4) begin
         n_fail++; $display("FAIL b2b_peak got=%0d exp=4", peak);
      end
      idle(2);
   endtask

   task automatic test_full();
      logic [31:0] a [6];
      int n = 0;
      logic exp_g, exp_v;
      int exp_id;
      for (int i = 0; i < 6; i++) a[i] = $urandom;
      for (int k = 0; k < 22; k++) begin
         drive(n < 6, 4'(n), a[n < 6 ? n : 0]);
         #1;
         exp_g  = (k < 4) || (k == 9) || (k == 10);
         exp_v  = (k >= 8 && k <= 11) || (k == 17) || (k == 18);
         exp_id = (k <= 11) ? k - 8 : k - 13;
         n_checks++;
         if (bus_if.mem_gnt !== exp_g) begin
            n_fail++; $display("FAIL full_gnt k=%0d got=%b exp=%b", k, bus_if.mem_gnt, exp_g);
         end
         n_checks++;
         if (bus_if.mem_rsp_pkt.valid !== exp_v) begin
            n_fail++; $display("FAIL full_valid k=%0d got=%b exp=%b", k, bus_if.mem_rsp_pkt.valid, exp_v);
         end
         if (exp_v) begin
            n_checks++;
            if ({bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr} !== {4'(exp_id), a[exp_id]}) begin
               n_fail++; $display("FAIL full_fields k=%0d got=%h exp=%h", k,
                                  {bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr}, {4'(exp_id), a[exp_id]});
            end
         end
         if (bus_if.mem_gnt === 1'b1) n++;
         next_cycle();
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      logic [31:0] a = $urandom;
      for (int k = 0; k < 19; k++) begin
         reset = (k == 4);
         drive((k < 3) || (k == 4) || (k == 6), (k == 6) ? 4'd5 : 4'(k), a);
         #1;
         n_checks++;
         if (bus_if.mem_gnt !== ((k < 3) || (k == 6))) begin
            n_fail++; $display("FAIL rmid_gnt k=%0d got=%b", k, bus_if.mem_gnt);
         end
         n_checks++;
         if (bus_if.mem_rsp_pkt.valid !== (k == 14)) begin
            n_fail++; $display("FAIL rmid_valid k=%0d got=%b exp=%b", k, bus_if.mem_rsp_pkt.valid, k == 14);
         end
         if (k == 3 || k == 5) begin
            n_checks++;
            if (num_outstanding !== ((k == 3) ? 3'd3 : 3'd0)) begin
               n_fail++; $display("FAIL rmid_cnt k=%0d got=%0d", k, num_outstanding);
            end
         end
         if (k == 14) begin
            n_checks++;
            if ({bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr} !== {4'd5, a}) begin
               n_fail++; $display("FAIL rmid_fields got=%h exp=%h",
                                  {bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr}, {4'd5, a});
            end
         end
         next_cycle();
      end
      reset = 1'b0;
      idle(4);
   endtask

   // Model: a request holds a slot from its grant cycle T through cycle T+L
   // (it answers in T+L and is re-grantable from T+L+1), so a grant is due
   // whenever fewer than Q grants fell in the previous L cycles.
   task automatic test_stream();
      int gq[$];
      logic [51:0] exp_q[$];
      int sent = 0;
      int c = 0;
      int outc;
      logic exp_g, exp_v;
      logic [3:0] id = 4'($urandom_range(0, 15));
      logic [31:0] addr = $urandom;
      logic [35:0] ef;
      while ((sent < 100 || exp_q.size() > 0) && c < 3000) begin
         drive(sent < 100, id, addr);
         #1;
         while (gq.size() > 0 && gq[0] < c - L) void'(gq.pop_front());
         outc = 0;
         foreach (gq[j]) if (gq[j] > c - L) outc++;
         exp_g = (sent < 100) && (gq.size() < Q);
         exp_v = (exp_q.size() > 0) && (exp_q[0][51:36] == 16'(c));
         n_checks++;
         if (bus_if.mem_gnt !== exp_g) begin
            n_fail++; $display("FAIL stream_gnt c=%0d got=%b exp=%b", c, bus_if.mem_gnt, exp_g);
         end
         n_checks++;
         if (num_outstanding !== 3'(outc)) begin
            n_fail++; $display("FAIL stream_cnt c=%0d got=%0d exp=%0d", c, num_outstanding, outc);
         end
         n_checks++;
         if (bus_if.mem_rsp_pkt.valid !== exp_v) begin
            n_fail++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus_if.mem_rsp_pkt.valid, exp_v);
         end
         if (exp_v) begin
            ef = exp_q[0][35:0];
            void'(exp_q.pop_front());
            n_checks++;
            if ({bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr, bus_if.mem_rsp_pkt.data} !==
                {ef, ef[31:0] + 32'd1, ef[31:0]}) begin
               n_fail++; $display("FAIL stream_fields c=%0d got=%h exp=%h", c,
                                  {bus_if.mem_rsp_pkt.id, bus_if.mem_rsp_pkt.addr}, ef);
            end
         end
         if (exp_g) begin
            gq.push_back(c);
            exp_q.push_back({16'(c + L), id, addr});
            sent++;
            id   = 4'($urandom_range(0, 15));
            addr = $urandom;
         end
         next_cycle();
         c++;
      end
      n_checks++;
      if (sent < 100 || exp_q.size() > 0) begin
         n_fail++; $display("FAIL stream_timeout sent=%0d pending=%0d exp=100/0", sent, exp_q.size());
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_stream();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
